// File: rtl/page_mux_pkg.sv
// Shared constants, state type and helpers for page_multi_leaf_mux and its FIFO.
package page_mux_pkg;

   localparam int PACKET_W_DEF  = 49;
   localparam int VALID_BIT_DEF = PACKET_W_DEF - 1;

   // Output register: IDLE drives an all-zero packet, SEND holds a packet.
   typedef enum logic {
      OUT_IDLE = 1'b0,
      OUT_SEND = 1'b1
   } out_state_t;

   // FIFO pointers carry one extra wrap bit so full and empty can be told apart.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Extract an unsigned field of 'width' bits at 'lsb' from a packet (packets up to 64 bits).
   function automatic int unsigned field_at(input logic [63:0] pkt, input int lsb, input int width);
      logic [63:0] mask;
      mask = (64'd1 << width) - 64'd1;
      return 32'((pkt >> lsb) & mask);
   endfunction

endpackage

// File: rtl/page_mux_fifo.sv
// Synchronous FIFO with combinational head-of-queue data, used once per page for outbound packets.
// A push on a full FIFO is only taken when a pop frees a slot in the same cycle.
module page_mux_fifo
   import page_mux_pkg::*;
#(
   parameter int WIDTH = PACKET_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int AW    = PTR_W - 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr_reg[AW-1:0]];

   // Advance read/write pointers on accepted pops and pushes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

endmodule

// File: rtl/page_multi_leaf_mux.sv
// Shares one BFT leaf port among NUM_PAGES page slots: inbound demux by channel field,
// outbound per-page FIFOs merged round-robin into a resend-aware output register.
// Optional statistics ports/counters are built when PAGE_MULTI_LEAF_MUX_STATS_EN is defined.
module page_multi_leaf_mux
   import page_mux_pkg::*;
#(
   parameter int PACKET_W   = PACKET_W_DEF,
   parameter int NUM_PAGES  = 4,
   parameter int CH_W       = 4,
   parameter int CH_LSB     = 44,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [PACKET_W-1:0]           din_leaf_bft2interface,
   output logic [PACKET_W-1:0]           dout_leaf_interface2bft,
   input  logic                          resend,
   input  logic [NUM_PAGES-1:0]          ap_start,
   output logic [NUM_PAGES*PACKET_W-1:0] page_din,
   input  logic [NUM_PAGES*PACKET_W-1:0] page_dout,
   output logic [NUM_PAGES-1:0]          page_resend,
   output logic [NUM_PAGES-1:0]          page_ap_start
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
   ,
   input  logic [CH_W-1:0]               stat_sel,
   output logic [15:0]                   stat_drop,
   output logic [15:0]                   stat_bad_ch
`endif
);

   localparam int VALID = PACKET_W - 1;
   localparam int SEL_W = $clog2(NUM_PAGES);

   logic [NUM_PAGES*PACKET_W-1:0] page_din_reg;
   logic [PACKET_W-1:0]           dout_reg, dout_next;
   logic [NUM_PAGES-1:0]          page_resend_reg, page_ap_start_reg;
   out_state_t                    state_reg, state_next;
   logic [SEL_W-1:0]              ptr_reg, ptr_next;
   logic [SEL_W-1:0]              cand, win;
   logic                          found;
   logic                          in_valid;
   int unsigned                   in_ch;
   logic [NUM_PAGES-1:0]          fifo_push, fifo_pop, fifo_full, fifo_empty, drop;
   logic [PACKET_W-1:0]           fifo_data [NUM_PAGES];

   assign in_valid = din_leaf_bft2interface[VALID];
   assign in_ch    = field_at(64'(din_leaf_bft2interface), CH_LSB, CH_W);

   assign page_din                = page_din_reg;
   assign dout_leaf_interface2bft = dout_reg;
   assign page_resend             = page_resend_reg;
   assign page_ap_start           = page_ap_start_reg;

   // Per-page outbound FIFO; a valid packet arriving at a full FIFO with no pop is dropped.
   generate
      for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_page
         logic [PACKET_W-1:0] pkt;
         assign pkt           = page_dout[gi*PACKET_W +: PACKET_W];
         assign fifo_push[gi] = pkt[VALID];
         assign drop[gi]      = pkt[VALID] && fifo_full[gi] && !fifo_pop[gi];

         page_mux_fifo #(
            .WIDTH (PACKET_W),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (fifo_push[gi]),
            .pop   (fifo_pop[gi]),
            .din   (pkt),
            .dout  (fifo_data[gi]),
            .full  (fifo_full[gi]),
            .empty (fifo_empty[gi])
         );
      end
   endgenerate

   // Inbound demux: route a valid packet to its channel slice one cycle later; bad channels vanish.
   always_ff @(posedge clk) begin
      if (reset) begin
         page_din_reg <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PAGES; i++) begin
            page_din_reg[i*PACKET_W +: PACKET_W] <=
               (in_valid && in_ch == i) ? din_leaf_bft2interface : '0;
         end
      end
   end

   // Round-robin pick from the pointer, unless a resend holds the packet currently on the leaf.
   always_comb begin
      state_next = state_reg;
      dout_next  = dout_reg;
      ptr_next   = ptr_reg;
      fifo_pop   = '0;
      found      = 1'b0;
      win        = '0;
      cand       = '0;
      for (int k = 0; k < NUM_PAGES; k++) begin
         cand = SEL_W'((int'(ptr_reg) + k) % NUM_PAGES);
         if (!found && !fifo_empty[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      if (!(state_reg == OUT_SEND && resend)) begin
         if (found) begin
            fifo_pop[win] = 1'b1;
            dout_next     = fifo_data[win];
            state_next    = OUT_SEND;
            ptr_next      = (win == SEL_W'(NUM_PAGES - 1)) ? '0 : win + 1'b1;
         end else begin
            dout_next  = '0;
            state_next = OUT_IDLE;
         end
      end
   end

   // Output register, arbiter pointer, overflow resend pulses and the ap_start delay.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= OUT_IDLE;
         dout_reg          <= '0;
         ptr_reg           <= '0;
         page_resend_reg   <= '0;
         page_ap_start_reg <= '0;
      end else begin
         state_reg         <= state_next;
         dout_reg          <= dout_next;
         ptr_reg           <= ptr_next;
         page_resend_reg   <= drop;
         page_ap_start_reg <= ap_start;
      end
   end

`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
   logic [15:0]      drop_cnt_reg [NUM_PAGES];
   logic [15:0]      bad_ch_reg;
   logic [SEL_W-1:0] stat_idx;

   // Saturating per-page overflow-drop counters.
   generate
      for (genvar gi = 0; gi < NUM_PAGES; gi++) begin : g_stat
         always_ff @(posedge clk) begin
            if (reset)
               drop_cnt_reg[gi] <= '0;
            else if (drop[gi] && drop_cnt_reg[gi] != 16'hFFFF)
               drop_cnt_reg[gi] <= drop_cnt_reg[gi] + 16'd1;
         end
      end
   endgenerate

   // Saturating count of valid inbound packets addressed past the last page.
   always_ff @(posedge clk) begin
      if (reset)
         bad_ch_reg <= '0;
      else if (in_valid && in_ch >= NUM_PAGES && bad_ch_reg != 16'hFFFF)
         bad_ch_reg <= bad_ch_reg + 16'd1;
   end

   assign stat_idx    = SEL_W'(stat_sel);
   assign stat_drop   = (32'(stat_sel) < NUM_PAGES) ? drop_cnt_reg[stat_idx] : 16'd0;
   assign stat_bad_ch = bad_ch_reg;
`endif

endmodule

// File: tb/tb_page_multi_leaf_mux.sv
// Bench for page_multi_leaf_mux: inbound vector table, hand sequences for arbitration,
// resend, overflow, reset and ap_start, then randomized traffic against a queue model.
module tb_page_multi_leaf_mux;

   localparam int PW    = 49;
   localparam int NP    = 4;
   localparam int DEPTH = 4;
   localparam int WD    = NP * PW;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] din, dout;
   logic          resend;
   logic [NP-1:0] ap_start, page_resend, page_ap_start;
   logic [WD-1:0] page_din, page_dout;
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
   logic [3:0]    stat_sel;
   logic [15:0]   stat_drop, stat_bad_ch;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   page_multi_leaf_mux #(
      .PACKET_W   (PW),
      .NUM_PAGES  (NP),
      .CH_W       (4),
      .CH_LSB     (44),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk                     (clk),
      .reset                   (reset),
      .din_leaf_bft2interface  (din),
      .dout_leaf_interface2bft (dout),
      .resend                  (resend),
      .ap_start                (ap_start),
      .page_din                (page_din),
      .page_dout               (page_dout),
      .page_resend             (page_resend),
      .page_ap_start           (page_ap_start)
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
      ,
      .stat_sel                (stat_sel),
      .stat_drop               (stat_drop),
      .stat_bad_ch             (stat_bad_ch)
`endif
   );

   typedef struct {
      logic [PW-1:0] din;
      int            exp_page;
      bit            bad;
   } in_vec_t;

   in_vec_t tbl [8];

   // Reference model state: per-page queues, leaf register, round-robin pointer.
   logic [PW-1:0] q [NP][$];
   logic [PW-1:0] m_dout;
   int            m_ptr;
   logic [WD-1:0] m_pd;
   logic [NP-1:0] m_presend, m_aps;

   task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end else begin
         $display("ok   %s value=%h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] mk_pkt(input int ch, input logic [31:0] pl);
      logic [PW-1:0] p;
      logic [3:0]    c;
      c = 4'(ch);
      p = '0;
      p[PW-1]   = 1'b1;
      p[44 +: 4] = c;
      p[31:0]   = pl;
      return p;
   endfunction

   function automatic logic [WD-1:0] slice_at(input int page, input logic [PW-1:0] pkt);
      logic [WD-1:0] v;
      v = '0;
      v[page*PW +: PW] = pkt;
      return v;
   endfunction

   task automatic do_reset();
      reset = 1'b1; din = '0; resend = 1'b0; ap_start = '0; page_dout = '0;
      step();
      reset = 1'b0;
   endtask

   // One clock of the behavioural model, using the inputs present before the edge.
   task automatic model_step();
      int ch;
      int idx;
      bit got;
      logic [PW-1:0] pkt;
      if (reset) begin
         for (int i = 0; i < NP; i++) q[i].delete();
         m_dout = '0; m_ptr = 0; m_pd = '0; m_presend = '0; m_aps = '0;
      end else begin
         ch   = int'(din[47:44]);
         m_pd = '0;
         if (din[PW-1] && ch < NP) m_pd[ch*PW +: PW] = din;
         if (!(m_dout[PW-1] && resend)) begin
            m_dout = '0;
            got    = 1'b0;
            for (int k = 0; k < NP; k++) begin
               idx = (m_ptr + k) % NP;
               if (!got && q[idx].size() > 0) begin
                  m_dout = q[idx].pop_front();
                  m_ptr  = (idx + 1) % NP;
                  got    = 1'b1;
               end
            end
         end
         for (int i = 0; i < NP; i++) begin
            pkt          = page_dout[i*PW +: PW];
            m_presend[i] = 1'b0;
            if (pkt[PW-1]) begin
               if (q[i].size() < DEPTH) q[i].push_back(pkt);
               else m_presend[i] = 1'b1;
            end
         end
         m_aps = ap_start;
      end
   endtask

   initial begin
      logic [PW-1:0] pa, pb, pc, pd;
      logic [PW-1:0] ov [6];
      logic [PW-1:0] tmp;
      logic [WD-1:0] exp;
      int            nbad;

      reset = 1'b1; din = '0; resend = 1'b0; ap_start = '0; page_dout = '0;
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
      stat_sel = '0;
`endif
      step(); step();
      check("reset_dout", WD'(dout), '0);
      check("reset_page_din", page_din, '0);
      check("reset_page_resend", WD'(page_resend), '0);
      check("reset_page_ap_start", WD'(page_ap_start), '0);
      reset = 1'b0;

      // Inbound demux table.
      tmp = mk_pkt(1, 32'h77); tmp[PW-1] = 1'b0;
      tbl[0] = '{mk_pkt(2, 32'hABCD), 2, 1'b0};
      tbl[1] = '{mk_pkt(7, 32'h1234), -1, 1'b1};
      tbl[2] = '{mk_pkt(0, 32'h1), 0, 1'b0};
      tbl[3] = '{mk_pkt(3, 32'hFFFF_FFFF), 3, 1'b0};
      tbl[4] = '{tmp, -1, 1'b0};
      tbl[5] = '{mk_pkt(1, 32'h5A5A), 1, 1'b0};
      tbl[6] = '{mk_pkt(15, 32'hDEAD), -1, 1'b1};
      tbl[7] = '{mk_pkt(4, 32'hBEEF), -1, 1'b1};
      nbad = 0;
      for (int i = 0; i < 8; i++) begin
         din = tbl[i].din;
         step();
         exp = (tbl[i].exp_page >= 0) ? slice_at(tbl[i].exp_page, tbl[i].din) : '0;
         check($sformatf("demux_vec%0d", i), page_din, exp);
         if (tbl[i].bad) nbad++;
      end
      din = '0;
      step();
      check("demux_idle", page_din, '0);
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
      check("stat_bad_ch", WD'(stat_bad_ch), WD'(nbad));
`endif

      // Round-robin: pages 0, 1, 3 push together.
      do_reset();
      pa = mk_pkt(0, 32'hA0); pb = mk_pkt(0, 32'hB1); pc = mk_pkt(0, 32'hC3);
      page_dout = slice_at(0, pa) | slice_at(1, pb) | slice_at(3, pc);
      step();
      page_dout = '0;
      check("rr_latency_gap", WD'(dout), '0);
      step(); check("rr_first_p0", WD'(dout), WD'(pa));
      step(); check("rr_second_p1", WD'(dout), WD'(pb));
      step(); check("rr_third_p3", WD'(dout), WD'(pc));
      step(); check("rr_idle", WD'(dout), '0);

      // Resend hold on page 1's packet; pointer must resume at page 2.
      do_reset();
      pa = mk_pkt(0, 32'h111); pb = mk_pkt(0, 32'h222); pc = mk_pkt(0, 32'h333);
      page_dout = slice_at(1, pa) | slice_at(2, pb);
      step();
      page_dout = '0;
      step();
      check("resend_first_p1", WD'(dout), WD'(pa));
      resend = 1'b1;
      page_dout = slice_at(0, pc);
      for (int i = 0; i < 3; i++) begin
         step();
         page_dout = '0;
         check($sformatf("resend_hold%0d", i), WD'(dout), WD'(pa));
      end
      resend = 1'b0;
      step(); check("resend_next_p2", WD'(dout), WD'(pb));
      step(); check("resend_wrap_p0", WD'(dout), WD'(pc));
      step(); check("resend_idle", WD'(dout), '0);

      // Overflow: six back-to-back pushes on page 0 while the leaf holds.
      do_reset();
      resend = 1'b1;
      for (int i = 0; i < 6; i++) ov[i] = mk_pkt(0, 32'h600 + 32'(i));
      for (int i = 0; i < 6; i++) begin
         page_dout = slice_at(0, ov[i]);
         step();
         check($sformatf("ovf_resend_e%0d", i + 1), WD'(page_resend), (i == 5) ? WD'(1) : '0);
      end
      page_dout = '0;
      check("ovf_hold_first", WD'(dout), WD'(ov[0]));
      step();
      check("ovf_resend_single", WD'(page_resend), '0);
`ifdef PAGE_MULTI_LEAF_MUX_STATS_EN
      stat_sel = 4'd0;
      #1 check("ovf_stat_drop", WD'(stat_drop), WD'(1));
`endif
      resend = 1'b0;
      for (int i = 1; i < 5; i++) begin
         step();
         check($sformatf("ovf_drain%0d", i), WD'(dout), WD'(ov[i]));
      end
      step(); check("ovf_sixth_dropped", WD'(dout), '0);

      // Reset while packets are buffered and one is on the leaf.
      do_reset();
      resend = 1'b1;
      pd = mk_pkt(0, 32'hD3);
      page_dout = slice_at(0, mk_pkt(0, 32'hD0)) | slice_at(1, mk_pkt(0, 32'hD1)) |
                  slice_at(2, mk_pkt(0, 32'hD2)) | slice_at(3, pd);
      step();
      page_dout = '0;
      step();
      din = mk_pkt(1, 32'hE1); ap_start = 4'b1111;
      reset = 1'b1;
      step();
      check("midrst_dout", WD'(dout), '0);
      check("midrst_page_din", page_din, '0);
      check("midrst_page_ap_start", WD'(page_ap_start), '0);
      reset = 1'b0; resend = 1'b0; din = '0; ap_start = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("midrst_no_stale%0d", i), WD'(dout), '0);
      end

      // ap_start is a one-cycle delay.
      ap_start = 4'b0101;
      step();
      ap_start = '0;
      check("ap_start_pulse", WD'(page_ap_start), WD'(4'b0101));
      step();
      check("ap_start_clear", WD'(page_ap_start), '0);

      // Randomized traffic against the queue model.
      reset = 1'b1;
      model_step();
      step();
      reset = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         reset = ($urandom_range(0, 99) == 0);
         resend = ($urandom_range(0, 1) == 1);
         ap_start = 4'($urandom);
         din = mk_pkt($urandom_range(0, 7), $urandom);
         if ($urandom_range(0, 3) == 0) din[PW-1] = 1'b0;
         for (int i = 0; i < NP; i++) begin
            tmp = PW'({$urandom, $urandom});
            tmp[PW-1] = ($urandom_range(0, 2) == 0);
            page_dout[i*PW +: PW] = tmp;
         end
         model_step();
         step();
         check($sformatf("rnd%0d_dout", cyc), WD'(dout), WD'(m_dout));
         check($sformatf("rnd%0d_page_din", cyc), page_din, m_pd);
         check($sformatf("rnd%0d_page_resend", cyc), WD'(page_resend), WD'(m_presend));
         check($sformatf("rnd%0d_ap_start", cyc), WD'(page_ap_start), WD'(m_aps));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
